// File: rtl/mio_bus_arbiter.sv
// Arbitrates the single-port MIO bus between instruction fetch and load/store requesters.
// Define MIO_TIMEOUT_EN to enable the watchdog that aborts accesses stuck longer than TIMEOUT_CYCLES.
module mio_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              mio_req,
  output logic              mio_we,
  output logic [ADDR_W-1:0] mio_addr,
  output logic [DATA_W-1:0] mio_wdata,
  input  logic [DATA_W-1:0] mio_rdata,
  input  logic              mio_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mio_err
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t            r_state;
  logic              r_last_data;
  logic              r_mio_req;
  logic              r_mio_we;
  logic [ADDR_W-1:0] r_mio_addr;
  logic [DATA_W-1:0] r_mio_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_if_valid;
  logic              r_mem_valid;

  logic              w_busy;
  logic              w_if_elig;
  logic              w_mem_elig;
  logic              w_last_data;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_grant;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata_in;

  assign w_busy = (r_state != IDLE);

  // A requester is ineligible while its own access is in flight or completing, and during its valid cycle,
  // so a request still held high after completion is never issued twice.
  assign w_if_elig  = if_req  & ~r_if_valid  & (r_state != I_BUSY);
  assign w_mem_elig = mem_req & ~r_mem_valid & (r_state != D_BUSY);

  // At a completion edge the grant history already reflects the access that is finishing.
  assign w_last_data = (r_state == D_BUSY) | ((r_state == IDLE) & r_last_data);
  assign w_grant_d   = w_mem_elig & ~(w_last_data & w_if_elig);
  assign w_grant_i   = w_if_elig & ~w_grant_d;
  assign w_grant     = w_grant_d | w_grant_i;

  assign w_done     = w_busy & (mio_ready | w_timeout);
  assign w_rdata_in = w_timeout ? DATA_W'(32'hDEADBEEF) : mio_rdata;

`ifdef MIO_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
  logic        r_mio_err;

  assign w_timeout = w_busy & ~mio_ready & (r_tmo_cnt == TIMEOUT_CYCLES - 1);
  assign mio_err   = r_mio_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_mio_err <= 1'b0;
    end else begin
      if (!w_busy || w_done) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + 32'd1;
      end
      if (w_timeout) begin
        r_mio_err <= 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;
  assign mio_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last_data <= 1'b0;
      r_mio_req   <= 1'b0;
      r_mio_we    <= 1'b0;
      r_mio_addr  <= '0;
      r_mio_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
    end else begin
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      if (w_done) begin
        if (r_state == I_BUSY) begin
          r_if_rdata  <= w_rdata_in;
          r_if_valid  <= 1'b1;
          r_last_data <= 1'b0;
        end else begin
          if (!r_mio_we || w_timeout) begin
            r_mem_rdata <= w_rdata_in;
          end
          r_mem_valid <= 1'b1;
          r_last_data <= 1'b1;
        end
      end
      // A normal completion re-arbitrates in the same edge; a watchdog abort always returns to IDLE.
      if ((!w_busy || (w_done && !w_timeout)) && w_grant) begin
        r_state     <= w_grant_d ? D_BUSY : I_BUSY;
        r_mio_req   <= 1'b1;
        r_mio_we    <= w_grant_d & mem_we;
        r_mio_addr  <= w_grant_d ? mem_addr : if_addr;
        r_mio_wdata <= w_grant_d ? mem_wdata : '0;
      end else if (!w_busy || w_done) begin
        r_state   <= IDLE;
        r_mio_req <= 1'b0;
        r_mio_we  <= 1'b0;
      end
    end
  end

  assign mio_req   = r_mio_req;
  assign mio_we    = r_mio_we;
  assign mio_addr  = r_mio_addr;
  assign mio_wdata = r_mio_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign mem_rdata = r_mem_rdata;
  assign mem_valid = r_mem_valid;
  assign stall_if  = if_req & ~r_if_valid;
  assign stall_mem = mem_req & ~r_mem_valid;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed self-checking bench for mio_bus_arbiter with a simple variable-latency memory model.
// The watchdog scenario runs when MIO_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mio_req;
  logic        mio_we;
  logic [31:0] mio_addr;
  logic [31:0] mio_wdata;
  logic [31:0] mio_rdata = '0;
  logic        mio_ready = 1'b0;
  logic        stall_if;
  logic        stall_mem;
  logic        mio_err;

  int errors = 0;
  int checks = 0;

  int          memLat = 0;
  logic        memHold = 1'b0;
  logic        memOverride = 1'b0;
  logic [31:0] memData = '0;
  int          busyCnt = 0;
  logic [31:0] doneLog[$];

  mio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .mio_req(mio_req), .mio_we(mio_we), .mio_addr(mio_addr), .mio_wdata(mio_wdata),
    .mio_rdata(mio_rdata), .mio_ready(mio_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .mio_err(mio_err)
  );

  always #5 clk = ~clk;

  // Memory answers after memLat waiting cycles; read data is memData or derived from the address.
  always @(negedge clk) begin
    if (mio_req && !memHold) begin
      if (busyCnt == memLat) begin
        mio_ready = 1'b1;
        mio_rdata = memOverride ? memData : (mio_addr ^ 32'hA5A5_0000);
        busyCnt = 0;
        doneLog.push_back(mio_addr);
      end else begin
        mio_ready = 1'b0;
        busyCnt++;
      end
    end else begin
      mio_ready = 1'b0;
      busyCnt = 0;
    end
  end

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mio_req got=%0b exp=0", mio_req); end
    checks++; if (mio_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mio_we got=%0b exp=0", mio_we); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_if_valid got=%0b exp=0", if_valid); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid got=%0b exp=0", mem_valid); end
    checks++; if (mio_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_mio_err got=%0b exp=0", mio_err); end
    checks++; if (mio_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mio_addr got=%h exp=0", mio_addr); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_if_rdata got=%h exp=0", if_rdata); end
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    memOverride = 1'b1;
    memData = 32'h2008_0005;
    memLat = 0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0000_0040;
    #1;
    checks++; if (stall_if !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_req got=%0b exp=1", stall_if); end
    @(negedge clk);
    checks++; if (mio_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_mio_req got=%0b exp=1", mio_req); end
    checks++; if (mio_addr !== 32'h40) begin errors++; $display("[TB] FAIL fetch_mio_addr got=%h exp=00000040", mio_addr); end
    checks++; if (mio_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_mio_we got=%0b exp=0", mio_we); end
    checks++; if (stall_if !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_busy got=%0b exp=1", stall_if); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_valid got=%0b exp=1", if_valid); end
    checks++; if (if_rdata !== 32'h2008_0005) begin errors++; $display("[TB] FAIL fetch_rdata got=%h exp=20080005", if_rdata); end
    checks++; if (stall_if !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_done got=%0b exp=0", stall_if); end
    if_req = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_valid_pulse got=%0b exp=0", if_valid); end
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_bus_idle got=%0b exp=0", mio_req); end
  endtask

  task automatic test_load_latency();
    int reqCycles = 0;
    logic seen = 1'b0;
    memOverride = 1'b1;
    memData = 32'h0000_1234;
    memLat = 3;
    @(negedge clk);
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h0000_0100;
    #1;
    checks++; if (stall_mem !== 1'b1) begin errors++; $display("[TB] FAIL load_stall got=%0b exp=1", stall_mem); end
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_valid) seen = 1'b1;
      else if (mio_req) reqCycles++;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL load_timeout got=no_valid exp=valid"); end
    checks++; if (reqCycles != 4) begin errors++; $display("[TB] FAIL load_req_cycles got=%0d exp=4", reqCycles); end
    checks++; if (mem_rdata !== 32'h0000_1234) begin errors++; $display("[TB] FAIL load_rdata got=%h exp=00001234", mem_rdata); end
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL load_bus_idle got=%0b exp=0", mio_req); end
    mem_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_valid_pulse got=%0b exp=0", mem_valid); end
  endtask

  task automatic test_back_to_back();
    applyReset();
    memOverride = 1'b0;
    memLat = 0;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0000_0300;
    mem_req = 1'b1;
    mem_we = 1'b1;
    mem_addr = 32'h0000_0200;
    mem_wdata = 32'h0000_CAFE;
    @(negedge clk);
    checks++; if (mio_we !== 1'b1) begin errors++; $display("[TB] FAIL b2b_store_we got=%0b exp=1", mio_we); end
    checks++; if (mio_addr !== 32'h200) begin errors++; $display("[TB] FAIL b2b_store_addr got=%h exp=00000200", mio_addr); end
    checks++; if (mio_wdata !== 32'hCAFE) begin errors++; $display("[TB] FAIL b2b_store_wdata got=%h exp=0000cafe", mio_wdata); end
    @(negedge clk);
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mem_valid got=%0b exp=1", mem_valid); end
    checks++; if (mio_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_bubble got=%0b exp=1", mio_req); end
    checks++; if (mio_we !== 1'b0) begin errors++; $display("[TB] FAIL b2b_fetch_we got=%0b exp=0", mio_we); end
    checks++; if (mio_addr !== 32'h300) begin errors++; $display("[TB] FAIL b2b_fetch_addr got=%h exp=00000300", mio_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_if_early got=%0b exp=0", if_valid); end
    mem_req = 1'b0;
    mem_we = 1'b0;
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_if_valid got=%0b exp=1", if_valid); end
    checks++; if (if_rdata !== 32'hA5A5_0300) begin errors++; $display("[TB] FAIL b2b_if_rdata got=%h exp=a5a50300", if_rdata); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("[TB] FAIL b2b_store_keeps_rdata got=%h exp=0", mem_rdata); end
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL b2b_bus_idle got=%0b exp=0", mio_req); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [31:0] expLog[6] = '{32'h180, 32'h44, 32'h180, 32'h44, 32'h180, 32'h44};
    int memCnt = 0;
    int ifCnt = 0;
    memOverride = 1'b0;
    memLat = 1;
    doneLog.delete();
    @(negedge clk);
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h0000_0180;
    if_req = 1'b1;
    if_addr = 32'h0000_0044;
    for (int c = 0; c < 60 && !(memCnt == 3 && ifCnt == 3); c++) begin
      @(negedge clk);
      if (mem_valid) memCnt++;
      if (if_valid) ifCnt++;
      if (memCnt == 3) mem_req = 1'b0;
      if (ifCnt == 3) if_req = 1'b0;
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    checks++; if (memCnt != 3 || ifCnt != 3) begin errors++; $display("[TB] FAIL alt_counts got=%0d/%0d exp=3/3", memCnt, ifCnt); end
    checks++; if (doneLog.size() != 6) begin errors++; $display("[TB] FAIL alt_log_size got=%0d exp=6", doneLog.size()); end
    for (int i = 0; i < 6 && i < doneLog.size(); i++) begin
      checks++;
      if (doneLog[i] !== expLog[i]) begin errors++; $display("[TB] FAIL alt_order[%0d] got=%h exp=%h", i, doneLog[i], expLog[i]); end
    end
    checks++; if (mem_rdata !== 32'hA5A5_0180) begin errors++; $display("[TB] FAIL alt_mem_rdata got=%h exp=a5a50180", mem_rdata); end
    checks++; if (if_rdata !== 32'hA5A5_0044) begin errors++; $display("[TB] FAIL alt_if_rdata got=%h exp=a5a50044", if_rdata); end
    @(negedge clk);
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL alt_bus_idle got=%0b exp=0", mio_req); end
  endtask

  task automatic test_reset_mid();
    logic sawValid = 1'b0;
    memHold = 1'b1;
    @(negedge clk);
    mem_req = 1'b1;
    mem_we = 1'b0;
    mem_addr = 32'h0000_0500;
    @(negedge clk);
    checks++; if (mio_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy got=%0b exp=1", mio_req); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_async_drop got=%0b exp=0", mio_req); end
    mem_req = 1'b0;
    @(negedge clk);
    if (mem_valid) sawValid = 1'b1;
    rst = 1'b1;
    memHold = 1'b0;
    memLat = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_valid) sawValid = 1'b1;
    end
    checks++; if (sawValid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_valid got=%0b exp=0", sawValid); end
    if_req = 1'b1;
    if_addr = 32'h0000_0080;
    @(negedge clk);
    checks++; if (mio_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_idle_grant got=%0b exp=1", mio_req); end
    checks++; if (mio_addr !== 32'h80) begin errors++; $display("[TB] FAIL rstmid_idle_addr got=%h exp=00000080", mio_addr); end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_fetch_valid got=%0b exp=1", if_valid); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

`ifdef MIO_TIMEOUT_EN
  task automatic test_timeout();
    int reqCycles = 0;
    logic seen = 1'b0;
    memHold = 1'b1;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = 32'h0000_0600;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (if_valid) seen = 1'b1;
      else if (mio_req) reqCycles++;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL tmo_valid got=no_valid exp=valid"); end
    checks++; if (reqCycles != 8) begin errors++; $display("[TB] FAIL tmo_busy_cycles got=%0d exp=8", reqCycles); end
    checks++; if (if_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL tmo_rdata got=%h exp=deadbeef", if_rdata); end
    checks++; if (mio_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err got=%0b exp=1", mio_err); end
    checks++; if (mio_req !== 1'b0) begin errors++; $display("[TB] FAIL tmo_bus_drop got=%0b exp=0", mio_req); end
    if_req = 1'b0;
    memHold = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mio_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_err_sticky got=%0b exp=1", mio_err); end
  endtask
`else
  task automatic test_no_timeout();
    checks++; if (mio_err !== 1'b0) begin errors++; $display("[TB] FAIL err_tied_low got=%0b exp=0", mio_err); end
  endtask
`endif

  initial begin
    $display("[TB] mio_bus_arbiter directed tests starting");
    test_reset();
    test_fetch();
    test_load_latency();
    test_back_to_back();
    test_alternate();
    test_reset_mid();
`ifdef MIO_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
